// File: rtl/lpm_latch_capture.sv
// lpm_latch_capture
//   Reader side of a level-sensitive latch. Each time the latch closes
//   (gate falls with no clear/set active), or a clear/set is newly applied,
//   the held value is snapshotted into a small first-word-fall-through FIFO.
//   A valid/ready consumer drains the FIFO. Captures that arrive while the
//   FIFO is full, with no pop in the same cycle, are dropped. A dropped
//   capture sets a sticky overflow flag.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   data       held latch value (latch q), synchronous to clock
//   gate       latch enable (1 = flow-through)
//   aclr/aset  latch clear/set controls, sampled on clock
//   out_data   FIFO head value (registered, held while empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head when out_valid & out_ready
//   count      number of entries held
//   overflow   sticky flag: a capture was dropped
//   ovf_clear  one-cycle pulse that clears overflow
module lpm_latch_capture #(
  parameter int lpm_width = 32,
  parameter int lpm_depth = 4,
  parameter     lpm_type  = "lpm_latch_capture"
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [lpm_width-1:0]         data,
  input  logic                         gate,
  input  logic                         aclr,
  input  logic                         aset,
  output logic [lpm_width-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(lpm_depth):0]   count,
  output logic                         overflow,
  input  logic                         ovf_clear
);

  localparam int PTR_W = $clog2(lpm_depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(lpm_depth);

  if ((lpm_depth < 2) || ((lpm_depth & (lpm_depth - 1)) != 0) || (lpm_type == "")) begin : g_param_check
    $error("lpm_latch_capture: lpm_depth must be a power of 2 and >= 2");
  end

  logic                 gate_d_r;
  logic                 force_d_r;
  logic [lpm_width-1:0] mem_r [lpm_depth];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 overflow_r;
  logic [lpm_width-1:0] out_data_r;
  logic                 out_valid_r;

  logic                 force_s;
  logic                 cap_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic [PTR_W-1:0]     rd_next_s;
  logic [CNT_W-1:0]     count_next_s;
  logic [lpm_width-1:0] head_next_s;

  // Edge detection on the latch controls and the FIFO accept decisions.
  always_comb begin
    force_s = aclr | aset;
    // A gate fall under an active clear/set is not a close; a held
    // clear/set captures only on its first cycle.
    cap_s   = (gate_d_r & ~gate & ~force_s) | (force_s & ~force_d_r);
    full_s  = (count_r == DEPTH_C);
    pop_s   = out_valid_r & out_ready;
    // When full, a capture is accepted only if a slot frees up this cycle.
    push_s  = cap_s & (~full_s | pop_s);
    drop_s  = cap_s & full_s & ~pop_s;
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
  end

  // Next occupancy and the value that will sit at the head after this edge.
  always_comb begin
    count_next_s = count_r;
    head_next_s  = out_data_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (count_next_s != CNT_ZERO) begin
      // The slot being written this cycle is the new head only when the
      // FIFO is otherwise empty after the pop; memory is not yet updated.
      if (push_s && (wr_ptr_r == rd_next_s)) begin
        head_next_s = data;
      end else begin
        head_next_s = mem_r[rd_next_s];
      end
    end else begin
      head_next_s = out_data_r;
    end
  end

  // Control-edge history registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_d_r  <= 1'b0;
      force_d_r <= 1'b0;
    end else begin
      gate_d_r  <= gate;
      force_d_r <= force_s;
    end
  end

  // FIFO storage, pointers, occupancy and registered head/valid outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < lpm_depth; i++) begin
        mem_r[i] <= {lpm_width{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      out_data_r  <= {lpm_width{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      out_data_r  <= head_next_s;
      out_valid_r <= (count_next_s != CNT_ZERO);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clear) begin
      overflow_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_lpm_latch_capture.sv
module tb_lpm_latch_capture;

  localparam int W = 32;
  localparam int D = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [W-1:0]  data;
  logic          gate, aclr, aset, out_ready, ovf_clear;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [2:0]    count;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of captured values plus control history.
  logic [W-1:0] m_q[$];
  bit           m_gate_d, m_force_d, m_ovf;
  logic [W-1:0] m_last;

  lpm_latch_capture #(.lpm_width(W), .lpm_depth(D)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .gate(gate),
    .aclr(aclr), .aset(aset), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow),
    .ovf_clear(ovf_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_gate_d  = 1'b0;
    m_force_d = 1'b0;
    m_ovf     = 1'b0;
    m_last    = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit f, cap, pop;
    int pre;
    f   = aclr | aset;
    cap = (m_gate_d && !gate && !f) || (f && !m_force_d);
    pre = m_q.size();
    pop = (pre > 0) && out_ready;
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (pre == D && !pop) m_ovf = 1'b1;
      else m_q.push_back(data);
    end
    if (!(cap && pre == D && !pop) && ovf_clear) m_ovf = 1'b0;
    m_gate_d  = gate;
    m_force_d = f;
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic compare_all();
    check("out_valid", W'(out_valid), W'(m_q.size() > 0));
    check("count", W'(count), W'(m_q.size()));
    check("overflow", W'(overflow), W'(m_ovf));
    check("out_data", out_data, m_last);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic close_with(input logic [W-1:0] v);
    gate = 1'b1; data = v; tick();
    gate = 1'b0; tick();
  endtask

  initial begin
    reset_n = 1'b0; data = '0; gate = 1'b0; aclr = 1'b0; aset = 1'b0;
    out_ready = 1'b0; ovf_clear = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_valid", W'(out_valid), 32'h0);
    check("rst_count", W'(count), 32'h0);
    check("rst_data", out_data, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    tick();

    // 1: flow-through then close captures the last value only
    gate = 1'b1; data = 32'h11; tick();
    data = 32'h22; tick();
    check("t1_no_valid_yet", W'(out_valid), 32'h0);
    gate = 1'b0; tick();
    check("t1_valid", W'(out_valid), 32'h1);
    check("t1_data", out_data, 32'h22);
    check("t1_count", W'(count), 32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 2: held clear captures once, then a one-cycle set
    aclr = 1'b1; data = 32'h0; tick(); tick(); tick();
    aclr = 1'b0; tick();
    aset = 1'b1; data = 32'hFFFF_FFFF; tick();
    aset = 1'b0; tick();
    check("t2_count", W'(count), 32'h2);
    check("t2_head", out_data, 32'h0);
    out_ready = 1'b1; tick();
    check("t2_second", out_data, 32'hFFFF_FFFF);
    tick(); out_ready = 1'b0;

    // 3: overflow with five closes into a four-deep FIFO
    for (int v = 1; v <= 5; v++) close_with(W'(v));
    check("t3_count", W'(count), 32'h4);
    check("t3_ovf", W'(overflow), 32'h1);
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check("t3_order", out_data, W'(v));
      tick();
    end
    out_ready = 1'b0;
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t3_ovf_clr", W'(overflow), 32'h0);

    // 4: capture coinciding with a pop while full
    for (int v = 0; v < 4; v++) close_with(32'hA1 + W'(v));
    gate = 1'b1; data = 32'hA5; tick();
    gate = 1'b0; out_ready = 1'b1; tick();
    check("t4_count", W'(count), 32'h4);
    check("t4_ovf", W'(overflow), 32'h0);
    for (int v = 0; v < 4; v++) begin
      check("t4_order", out_data, 32'hA2 + W'(v));
      tick();
    end
    out_ready = 1'b0;

    // 5: gate fall and set rise together give a single capture
    gate = 1'b1; data = 32'h55; tick();
    gate = 1'b0; aset = 1'b1; tick();
    aset = 1'b0; tick();
    check("t5_count", W'(count), 32'h1);
    check("t5_data", out_data, 32'h55);

    // 6: asynchronous reset with three entries queued
    close_with(32'h66); close_with(32'h77);
    check("t6_pre_count", W'(count), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", W'(out_valid), 32'h0);
    check("t6_count", W'(count), 32'h0);
    check("t6_ovf", W'(overflow), 32'h0);
    model_reset();
    #2 reset_n = 1'b1;
    tick(); tick(); tick();
    check("t6_no_cap", W'(count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
